// File: rtl/mem_lsu_pkg.sv
// Purpose: shared size encodings, FSM state type and lane widths for the load/store unit.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package mem_lsu_pkg;

    localparam int WORD_W = 32;
    localparam int HALF_W = 16;
    localparam int BYTE_W = 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // A request is rejected when its size is illegal or its address is not
    // naturally aligned to that size.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Purpose: little-endian lane extract (load) and lane merge (sub-word store) for one 32-bit word.
// Latency: combinational.
// Backpressure: none.
// Ports: i_word memory word, i_addr_lo byte offset, i_size/i_signed access type, i_wdata
//        right-aligned store data; o_load extended load value, o_merged word to write back.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    input  logic [1:0]        i_addr_lo,
    input  logic [1:0]        i_size,
    input  logic              i_signed,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_load,
    output logic [WORD_W-1:0] o_merged
);

    logic [BYTE_W-1:0] lane_b;
    logic [HALF_W-1:0] lane_h;

    always_comb begin
        lane_b   = i_word[BYTE_W*i_addr_lo +: BYTE_W];
        lane_h   = i_addr_lo[1] ? i_word[WORD_W-1:HALF_W] : i_word[HALF_W-1:0];
        o_load   = i_word;
        o_merged = i_word;
        case (i_size)
            SZ_BYTE: begin
                o_load = {{(WORD_W-BYTE_W){i_signed & lane_b[BYTE_W-1]}}, lane_b};
                o_merged[BYTE_W*i_addr_lo +: BYTE_W] = i_wdata[BYTE_W-1:0];
            end
            SZ_HALF: begin
                o_load = {{(WORD_W-HALF_W){i_signed & lane_h[HALF_W-1]}}, lane_h};
                o_merged[HALF_W*i_addr_lo[1] +: HALF_W] = i_wdata[HALF_W-1:0];
            end
            SZ_WORD: begin
                o_merged = i_wdata;
            end
            default: begin
                o_load   = i_word;
                o_merged = i_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Purpose: single-outstanding load/store unit to a word-addressed memory, with sub-word RMW.
// Latency: accept->rsp 1 cycle (error), 2 (load, word store), 3 (byte/half store).
// Backpressure: o_req_ready only in IDLE; response is a one-cycle pulse with no backpressure.
// Ports: i_req_* request (valid/ready), o_rsp_* completion, o_mem_* / i_mem_data memory side.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_signed,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic                  o_mem_we,
    input  logic [DATA_WIDTH-1:0] i_mem_data
);

    state_e                  state_q, state_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    sgn_q, sgn_d;
    logic [1:0]              addr_lo_q, addr_lo_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
    logic [DATA_WIDTH-1:0]   load_val;
    logic [DATA_WIDTH-1:0]   merged;

    // Alignment works from the latched request; it is only consumed in READ.
    mem_lsu_align u_align (
        .i_word    (i_mem_data),
        .i_addr_lo (addr_lo_q),
        .i_size    (size_q),
        .i_signed  (sgn_q),
        .i_wdata   (wdata_q),
        .o_load    (load_val),
        .o_merged  (merged)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        sgn_d      = sgn_q;
        addr_lo_d  = addr_lo_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    we_d      = i_req_we;
                    size_d    = i_req_size;
                    sgn_d     = i_req_signed;
                    addr_lo_d = i_req_addr[1:0];
                    wdata_d   = i_req_wdata;
                    err_d     = req_bad(i_req_size, i_req_addr[1:0]);
                    // Stores and errors report zero; loads overwrite this in READ.
                    rdata_d   = '0;
                    if (err_d) begin
                        // Memory-side outputs keep their previous values on errors.
                        state_d = ST_RESP;
                    end else begin
                        mem_addr_d = i_req_addr >> 2;
                        if (i_req_we && (i_req_size == SZ_WORD)) begin
                            mem_data_d = i_req_wdata;
                            state_d    = ST_WRITE;
                        end else begin
                            // Loads and sub-word stores both need the current word.
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                if (we_q) begin
                    mem_data_d = merged;
                    state_d    = ST_WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sgn_q      <= 1'b0;
            addr_lo_q  <= 2'b00;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            sgn_q      <= sgn_d;
            addr_lo_q  <= addr_lo_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Decoded straight from the state so reset drops them without waiting for a clock.
    assign o_req_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_err   = (state_q == ST_RESP) & err_q;
    assign o_mem_we    = (state_q == ST_WRITE);
    assign o_rsp_rdata = rdata_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_data  = mem_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Purpose: self-checking bench for mem_lsu against a 32-word memory and a behavioural reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        preload;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [32];
    logic [31:0] ref_mem [32];

    int checks   = 0;
    int failures = 0;

    mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_size   (req_size),
        .i_req_signed (req_signed),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_mem_addr   (mem_addr),
        .o_mem_data   (mem_wdata),
        .o_mem_we     (mem_we),
        .i_mem_data   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pre_val(input int i);
        return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0107);
    endfunction

    // 32-word memory: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= pre_val(i);
        end else if (mem_we) begin
            mem[mem_addr[4:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[4:0]];

    // ---------------- reference model ----------------
    function automatic logic ref_bad(input logic [1:0] sz, input logic [1:0] lo);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1) return (lo % 2) != 0;
        if (sz == 2'd2) return lo != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] lo);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (lo * 8)) & 32'hFF;
            if (sg && v >= 32'h80) v = v - 32'h100;
        end else if (sz == 2'd1) begin
            v = (w >> ((lo / 2) * 16)) & 32'hFFFF;
            if (sg && v >= 32'h8000) v = v - 32'h10000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] lo, input logic [31:0] wd);
        logic [31:0] m;
        if (sz == 2'd0) begin
            m = 32'hFF << (lo * 8);
            return (w & ~m) | ((wd & 32'hFF) << (lo * 8));
        end else if (sz == 2'd1) begin
            m = 32'hFFFF << ((lo / 2) * 16);
            return (w & ~m) | ((wd & 32'hFFFF) << ((lo / 2) * 16));
        end
        return wd;
    endfunction

    // Drive one request from IDLE, then observe until the response (bounded).
    // lat = samples from accept to rsp (0 = never seen); hs_bad flags a ready
    // seen high while busy, or a response that is not a single-cycle pulse.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int nwe, output logic [31:0] wa, output logic [31:0] wdt,
                           output logic hs_bad);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = ad;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        // Fields must have been captured at accept; scramble them now.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 0; nwe = 0; rd = '0; er = 1'b0; wa = '0; wdt = '0; hs_bad = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (req_ready !== 1'b0) hs_bad = 1'b1;
            if (mem_we === 1'b1) begin
                nwe++;
                wa  = mem_addr;
                wdt = mem_wdata;
            end
            if (rsp_valid === 1'b1) begin
                lat = c;
                rd  = rsp_rdata;
                er  = rsp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (lat != 0) begin
            @(posedge clk);
            #1;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0) hs_bad = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: ready=%b rsp_valid=%b err=%b we=%b, need 1 0 0 0",
                     req_ready, rsp_valid, rsp_err, mem_we);
        end
        checks++;
        if (rsp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, need all 0",
                     rsp_rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_word_store();
        int lat, nwe; logic [31:0] rd, wa, wdt; logic er, hb;
        run_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, lat, rd, er, nwe, wa, wdt, hb);
        checks++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'h0) begin
            failures++;
            $display("FAIL word_store_rsp: lat=%0d err=%b rdata=%h, need 2 0 0", lat, er, rd);
        end
        checks++;
        if (nwe != 1 || wa !== 32'h2 || wdt !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL word_store_mem: we_cycles=%0d addr=%h data=%h, need 1 2 deadbeef", nwe, wa, wdt);
        end
        checks++;
        if (mem[2] !== 32'hDEADBEEF || hb) begin
            failures++;
            $display("FAIL word_store_word: mem2=%h hs_bad=%b, need deadbeef 0", mem[2], hb);
        end
        ref_mem[2] = 32'hDEADBEEF;
    endtask

    task automatic test_byte_load();
        int lat, nwe; logic [31:0] rd, wa, wdt; logic er, hb;
        run_req(1'b0, 2'd0, 1'b1, 32'hB, 32'h0, lat, rd, er, nwe, wa, wdt, hb);
        checks++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'hFFFFFFDE || nwe != 0 || hb) begin
            failures++;
            $display("FAIL byte_load_signed: lat=%0d err=%b rdata=%h we=%0d hs=%b, need 2 0 ffffffde 0 0",
                     lat, er, rd, nwe, hb);
        end
        run_req(1'b0, 2'd0, 1'b0, 32'hB, 32'h0, lat, rd, er, nwe, wa, wdt, hb);
        checks++;
        if (lat != 2 || er !== 1'b0 || rd !== 32'h000000DE || nwe != 0) begin
            failures++;
            $display("FAIL byte_load_unsigned: lat=%0d err=%b rdata=%h we=%0d, need 2 0 000000de 0",
                     lat, er, rd, nwe);
        end
    endtask

    task automatic test_byte_store();
        int lat, nwe; logic [31:0] rd, wa, wdt; logic er, hb;
        logic [31:0] wd;
        wd = {24'($urandom), 8'h12};
        run_req(1'b1, 2'd0, 1'b0, 32'h9, wd, lat, rd, er, nwe, wa, wdt, hb);
        checks++;
        if (lat != 3 || er !== 1'b0 || rd !== 32'h0 || hb) begin
            failures++;
            $display("FAIL byte_store_rsp: lat=%0d err=%b rdata=%h hs=%b, need 3 0 0 0", lat, er, rd, hb);
        end
        checks++;
        if (nwe != 1 || wdt !== 32'hDEAD12EF || mem[2] !== 32'hDEAD12EF) begin
            failures++;
            $display("FAIL byte_store_mem: we_cycles=%0d data=%h mem2=%h, need 1 dead12ef dead12ef",
                     nwe, wdt, mem[2]);
        end
        ref_mem[2] = 32'hDEAD12EF;
    endtask

    task automatic test_errors();
        int lat, nwe; logic [31:0] rd, wa, wdt; logic er, hb;
        run_req(1'b0, 2'd1, 1'b1, 32'h5, 32'h0, lat, rd, er, nwe, wa, wdt, hb);
        checks++;
        if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || nwe != 0 || hb) begin
            failures++;
            $display("FAIL err_misaligned_half: lat=%0d err=%b rdata=%h we=%0d hs=%b, need 1 1 0 0 0",
                     lat, er, rd, nwe, hb);
        end
        run_req(1'b1, 2'd3, 1'b0, 32'h0, 32'hCAFEF00D, lat, rd, er, nwe, wa, wdt, hb);
        checks++;
        if (lat != 1 || er !== 1'b1 || rd !== 32'h0 || nwe != 0 || mem[0] !== ref_mem[0]) begin
            failures++;
            $display("FAIL err_size11: lat=%0d err=%b rdata=%h we=%0d mem0=%h, need 1 1 0 0 %h",
                     lat, er, rd, nwe, mem[0], ref_mem[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic r1, r2, v2, r3, v3, r4, w4, v5, e5;
        logic [31:0] d2, a4, d4, wd2;
        wd2 = $urandom;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'h8; req_wdata = 32'h0;
        @(posedge clk); #1; r1 = req_ready;
        @(posedge clk); #1; r2 = req_ready; v2 = rsp_valid; d2 = rsp_rdata;
        // Valid stays high; the second request only takes effect once IDLE is reached.
        req_we = 1'b1; req_addr = 32'hC; req_wdata = wd2;
        @(posedge clk); #1; r3 = req_ready; v3 = rsp_valid;
        @(posedge clk); #1; r4 = req_ready; w4 = mem_we; a4 = mem_addr; d4 = mem_wdata;
        req_valid = 1'b0;
        @(posedge clk); #1; v5 = rsp_valid; e5 = rsp_err;
        @(posedge clk); #1;
        checks++;
        if (r1 !== 1'b0 || r2 !== 1'b0 || v2 !== 1'b1 || d2 !== ref_mem[2]) begin
            failures++;
            $display("FAIL b2b_first: ready=%b,%b rsp=%b rdata=%h, need 0,0 1 %h", r1, r2, v2, d2, ref_mem[2]);
        end
        checks++;
        if (r3 !== 1'b1 || v3 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: ready=%b rsp=%b after RESP, need 1 0", r3, v3);
        end
        checks++;
        if (r4 !== 1'b0 || w4 !== 1'b1 || a4 !== 32'h3 || d4 !== wd2 || v5 !== 1'b1 || e5 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second: ready=%b we=%b addr=%h data=%h rsp=%b err=%b, need 0 1 3 %h 1 0",
                     r4, w4, a4, d4, v5, e5, wd2);
        end
        checks++;
        if (mem[3] !== wd2) begin
            failures++;
            $display("FAIL b2b_mem: mem3=%h, need %h", mem[3], wd2);
        end
        ref_mem[3] = wd2;
    endtask

    task automatic test_reset_abort();
        logic busy, saw;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h6; req_wdata = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b0;
        busy = req_ready;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_we !== 1'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL abort_async: busy=%b ready=%b rsp=%b we=%b addr=%h data=%h rdata=%h, need 0 1 0 0 0 0 0",
                     busy, req_ready, rsp_valid, mem_we, mem_addr, mem_wdata, rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        saw = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0 || mem_we !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw || req_ready !== 1'b1 || mem[1] !== ref_mem[1]) begin
            failures++;
            $display("FAIL abort_after: activity=%b ready=%b mem1=%h, need 0 1 %h",
                     saw, req_ready, mem[1], ref_mem[1]);
        end
    endtask

    task automatic test_random();
        int lat, nwe, exp_lat, exp_nwe;
        logic [31:0] rd, wa, wdt, exp_rd, exp_w, ad, wd;
        logic er, hb, we, sg, bad;
        logic [1:0] sz;
        logic [4:0] idx;
        for (int n = 0; n < 150; n++) begin
            we  = 1'($urandom);
            sz  = 2'($urandom);
            sg  = 1'($urandom);
            ad  = $urandom_range(0, 127);
            wd  = $urandom;
            idx = ad[6:2];
            bad = ref_bad(sz, ad[1:0]);
            exp_rd = 32'h0;
            exp_w  = ref_mem[idx];
            exp_nwe = 0;
            if (bad) begin
                exp_lat = 1;
            end else if (!we) begin
                exp_lat = 2;
                exp_rd  = ref_load(ref_mem[idx], sz, sg, ad[1:0]);
            end else begin
                exp_lat = (sz == 2'd2) ? 2 : 3;
                exp_w   = ref_store(ref_mem[idx], sz, ad[1:0], wd);
                exp_nwe = 1;
            end
            run_req(we, sz, sg, ad, wd, lat, rd, er, nwe, wa, wdt, hb);
            checks++;
            if (lat != exp_lat || er !== bad || rd !== exp_rd) begin
                failures++;
                $display("FAIL rand_rsp n=%0d: lat=%0d err=%b rdata=%h, need %0d %b %h",
                         n, lat, er, rd, exp_lat, bad, exp_rd);
            end
            checks++;
            if (nwe != exp_nwe || (exp_nwe == 1 && (wa !== (ad >> 2) || wdt !== exp_w))) begin
                failures++;
                $display("FAIL rand_write n=%0d: we_cycles=%0d addr=%h data=%h, need %0d %h %h",
                         n, nwe, wa, wdt, exp_nwe, ad >> 2, exp_w);
            end
            checks++;
            if (mem[idx] !== exp_w || hb) begin
                failures++;
                $display("FAIL rand_mem n=%0d: word=%h hs_bad=%b, need %h 0", n, mem[idx], hb, exp_w);
            end
            ref_mem[idx] = exp_w;
        end
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < 32; i++) ref_mem[i] = pre_val(i);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        preload = 1'b0;
        rst = 1'b0;
        test_word_store();
        test_byte_load();
        test_byte_store();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, the width of the byte request address and the word-index memory address.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the word width; only 32 is supported.
REQ-003 i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous and active-high.
REQ-005 i_req_valid  input  1  request present.
REQ-006 o_req_ready  output  1  block can accept a request.
REQ-007 i_req_we  input  1  1 = store, 0 = load.
REQ-008 i_req_size  input  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 i_req_signed  input  1  sign-extend load data; ignored for word and for stores.
REQ-010 i_req_addr  input  ADDR_WIDTH  byte address.
REQ-011 i_req_wdata  input  32  store data, right-aligned (bits 7:0 byte, 15:0 half).
REQ-012 o_rsp_valid  output  1  one-cycle completion pulse.
REQ-013 o_rsp_rdata  output  32  load result, extended per size and signed; 0 for stores and errors.
REQ-014 o_rsp_err  output  1  misaligned or illegal-size request; valid with o_rsp_valid.
REQ-015 o_mem_addr  output  ADDR_WIDTH  word index to the memory, equal to i_req_addr >> 2 zero-filled.
REQ-016 o_mem_data  output  32  write word to the memory.
REQ-017 o_mem_we  output  1  memory write enable; the memory writes on the rising edge when it is high.
REQ-018 i_mem_data  input  32  memory read word, combinational from o_mem_addr.

Function
REQ-019 The FSM SHALL have states IDLE, READ, WRITE and RESP; o_req_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE, i_req_valid = 1 SHALL latch all request fields and transition per REQ-021 to REQ-024.
REQ-021 Misaligned (half with addr[0] = 1, word with addr[1:0] != 0) or size 11 SHALL go to RESP with o_rsp_err = 1 and no memory write.
REQ-022 A load SHALL go to READ, then to RESP; its latency is 2 cycles from accept to o_rsp_valid.
REQ-023 A word store SHALL go to WRITE, then to RESP; its latency is 2 cycles.
REQ-024 A byte or half store SHALL go to READ, then WRITE, then RESP (read-modify-write); its latency is 3 cycles.
REQ-025 In READ, the block SHALL drive o_mem_addr and register i_mem_data at the end of the cycle.
REQ-026 In WRITE, o_mem_we SHALL be 1 for exactly one cycle; the write word is wdata for word stores, or the read word with the addressed lane replaced for sub-word stores.
REQ-027 Lanes SHALL be little-endian: byte k occupies bits 8k+7:8k, and half h = addr[1] occupies bits 16h+15:16h.
REQ-028 Outside WRITE, o_mem_we SHALL be 0; outside READ and WRITE, o_mem_addr and o_mem_data SHALL hold their last values.
REQ-029 RESP SHALL last one cycle with o_rsp_valid = 1 (no backpressure), then return to IDLE; a new request SHALL be accepted no earlier than the following cycle.
REQ-030 i_req_valid SHALL be ignored outside IDLE; request inputs SHALL be sampled only at accept.
REQ-031 For loads, o_rsp_rdata SHALL be zero-extended unless i_req_signed = 1, in which case it SHALL be sign-extended from bit 7 (byte) or bit 15 (half).

Reset
REQ-032 i_rst SHALL immediately force IDLE, o_req_ready = 1, and o_rsp_valid, o_rsp_err, o_mem_we = 0.
REQ-033 i_rst SHALL immediately force o_rsp_rdata, o_mem_addr, o_mem_data and all latched request fields to 0.
REQ-034 Reset during READ or WRITE SHALL abort the access with no memory write after reset assertion and no response.

Structure
REQ-035 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum and the lane-width constants.
REQ-036 Lane extraction and lane merge SHALL be a combinational sub-module mem_lsu_align (inputs word, addr[1:0], size, signed, wdata; outputs load value, merged word).
REQ-037 The verification bench SHALL pair mem_lsu with the team's 32-word memory model.

Verification
REQ-038 Word store addr 0x8, wdata 0xDEADBEEF -> o_mem_we for one cycle with o_mem_addr 2 and o_mem_data 0xDEADBEEF; rsp 2 cycles after accept, err 0.
REQ-039 Signed byte load addr 0xB after REQ-038 -> rdata 0xFFFFFFDE at 2 cycles; unsigned -> 0x000000DE.
REQ-040 Byte store addr 0x9, wdata 0x12 over 0xDEADBEEF -> memory word 2 becomes 0xDEAD12EF; rsp 3 cycles after accept.
REQ-041 Half load addr 0x5, or size 11 -> rsp 1 cycle after accept with err 1, rdata 0, no o_mem_we.
REQ-042 Back-to-back requests held valid -> ready low from accept until after RESP; the second request is accepted in the cycle after RESP.
REQ-043 i_rst pulsed while in READ of a half store -> no write occurs, memory word unchanged, ready 1, no rsp.
